// File: rtl/sync_det_pkg.sv
// Shared types and constants for the sync timing detector.
package sync_det_pkg;

   // Lock acquisition state
   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      VERIFY  = 2'd2,
      LOCK    = 2'd3
   } det_state_t;

   localparam int HW_DEF          = 11;
   localparam int VW_DEF          = 10;
   localparam int LOCK_FRAMES_DEF = 2;

   // Sync lines idle high, so synchronizer stages reset high to avoid a false edge on release
   localparam logic SYNC_RST_VAL = 1'b1;

   // Level run-length counter width used by automatic polarity detection
   localparam int POL_CW = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered pulse-start detector.
// With SYNC_DET_POLARITY_AUTO_EN defined, the shorter of the two input levels
// is taken as the pulse and the detector fires on its leading edge; the
// polarity decision holds while freeze is high.
module sync_edge_detect
   import sync_det_pkg::*;
(
   input  logic CLK,
   input  logic RST,
   input  logic sync_in,
`ifdef SYNC_DET_POLARITY_AUTO_EN
   input  logic freeze,
`endif
   output logic edge_pulse
);

   logic s1_reg, s2_reg, s3_reg, pulse_reg;
   logic lvl_now, lvl_prev;

   // Synchronizer, previous-level register and registered edge pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_reg    <= SYNC_RST_VAL;
         s2_reg    <= SYNC_RST_VAL;
         s3_reg    <= SYNC_RST_VAL;
         pulse_reg <= 1'b0;
      end else begin
         s1_reg    <= sync_in;
         s2_reg    <= s1_reg;
         s3_reg    <= s2_reg;
         pulse_reg <= lvl_prev & ~lvl_now;
      end
   end

`ifdef SYNC_DET_POLARITY_AUTO_EN
   logic [POL_CW-1:0] run_reg, hi_len_reg, lo_len_reg;
   logic              hi_seen_reg, lo_seen_reg, inv_reg;

   // Measure the length of each level run; invert when the high level is the short one
   always_ff @(posedge CLK) begin
      if (RST) begin
         run_reg     <= '0;
         hi_len_reg  <= '0;
         lo_len_reg  <= '0;
         hi_seen_reg <= 1'b0;
         lo_seen_reg <= 1'b0;
         inv_reg     <= 1'b0;
      end else begin
         if (s2_reg != s3_reg) begin
            run_reg <= POL_CW'(1);
            if (s3_reg) begin
               hi_len_reg  <= run_reg;
               hi_seen_reg <= 1'b1;
            end else begin
               lo_len_reg  <= run_reg;
               lo_seen_reg <= 1'b1;
            end
         end else if (run_reg != '1) begin
            run_reg <= run_reg + POL_CW'(1);
         end
         if (!freeze && hi_seen_reg && lo_seen_reg)
            inv_reg <= (hi_len_reg < lo_len_reg);
      end
   end

   // Both taps share the same inversion, so a polarity change never creates an edge
   assign lvl_now  = s2_reg ^ inv_reg;
   assign lvl_prev = s3_reg ^ inv_reg;
`else
   assign lvl_now  = s2_reg;
   assign lvl_prev = s3_reg;
`endif

   assign edge_pulse = pulse_reg;

endmodule

// File: rtl/sync_timing_detector.sv
// Measures HSYNC/VSYNC timing, regenerates X/Y position and reports lock.
// Optional build macro: SYNC_DET_POLARITY_AUTO_EN (automatic sync polarity).
module sync_timing_detector
   import sync_det_pkg::*;
#(
   parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
   parameter int HW          = HW_DEF,
   parameter int VW          = VW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          HSYNC_IN,
   input  logic          VSYNC_IN,
   output logic          LOCKED,
   output logic [HW-1:0] H_TOTAL,
   output logic [VW-1:0] V_TOTAL,
   output logic [HW-1:0] X,
   output logic [VW-1:0] Y,
   output logic          FRAME_STB,
   output logic          LOSS
);

   localparam logic [HW-1:0] HMAX = '1;
   localparam logic [VW-1:0] VMAX = '1;
   localparam logic [4:0]    LF   = 5'(LOCK_FRAMES);

   det_state_t    state_reg, state_next;
   logic [1:0]    sync_raw, sync_edge;
   logic          he, ve, x_sat, frame_match, cnt_done;
   logic [HW-1:0] x_reg, p_reg, pc_reg, h_total_reg;
   logic [VW-1:0] y_reg, fc_reg, v_total_reg, f_meas;
   logic [3:0]    match_cnt_reg;
   logic          frame_stb_reg, loss_reg;
   logic          frame_stb_next, loss_next, cand_load, lock_load, cnt_inc;

   assign sync_raw = {VSYNC_IN, HSYNC_IN};

   // Index 0 is HSYNC, index 1 is VSYNC
   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync_edge_detect u_det (
         .CLK        (CLK),
         .RST        (RST),
         .sync_in    (sync_raw[gi]),
`ifdef SYNC_DET_POLARITY_AUTO_EN
         .freeze     ((state_reg == VERIFY) || (state_reg == LOCK)),
`endif
         .edge_pulse (sync_edge[gi])
      );
   end

   assign he = sync_edge[0];
   assign ve = sync_edge[1];

   // Y is a 1-based line index, so the HE pulses seen since the last VE are Y-1
   assign f_meas      = (y_reg == '0) ? '0 : y_reg - VW'(1);
   assign x_sat       = (x_reg == HMAX);
   assign frame_match = (f_meas == fc_reg) && (p_reg == pc_reg);
   assign cnt_done    = ({1'b0, match_cnt_reg} + 5'd1) >= LF;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) state_reg <= SEARCH;
      else     state_reg <= state_next;
   end

   // Next-state logic; a saturated X means the line sync has gone away
   always_comb begin
      state_next = state_reg;
      if (x_sat) begin
         state_next = SEARCH;
      end else begin
         case (state_reg)
            SEARCH:  if (ve) state_next = MEASURE;
            MEASURE: if (ve) state_next = VERIFY;
            VERIFY: begin
               if (he && (x_reg != pc_reg))
                  state_next = SEARCH;
               else if (ve)
                  state_next = frame_match ? (cnt_done ? LOCK : VERIFY) : MEASURE;
            end
            LOCK: begin
               if ((he && (x_reg != h_total_reg)) || (ve && (f_meas != v_total_reg)))
                  state_next = SEARCH;
            end
            default: state_next = SEARCH;
         endcase
      end
   end

   // Output and datapath control decoded from the transition
   always_comb begin
      frame_stb_next = ve && (state_next == LOCK);
      loss_next      = (state_reg == LOCK) && (state_next != LOCK);
      cand_load      = (state_reg == MEASURE) && (state_next == VERIFY);
      lock_load      = (state_reg == VERIFY) && (state_next == LOCK);
      cnt_inc        = (state_reg == VERIFY) && (state_next == VERIFY) && ve;
   end

   // Position counters, period capture, candidate and locked totals
   always_ff @(posedge CLK) begin
      if (RST) begin
         x_reg         <= '0;
         y_reg         <= '0;
         p_reg         <= '0;
         pc_reg        <= '0;
         fc_reg        <= '0;
         match_cnt_reg <= '0;
         h_total_reg   <= '0;
         v_total_reg   <= '0;
         frame_stb_reg <= 1'b0;
         loss_reg      <= 1'b0;
      end else begin
         if (he) begin
            p_reg <= x_reg;
            x_reg <= HW'(1);
         end else if (!x_sat) begin
            x_reg <= x_reg + HW'(1);
         end
         if (ve)
            y_reg <= VW'(1);
         else if (he && (y_reg != VMAX))
            y_reg <= y_reg + VW'(1);
         if (cand_load) begin
            pc_reg        <= p_reg;
            fc_reg        <= f_meas;
            match_cnt_reg <= '0;
         end else if (cnt_inc) begin
            match_cnt_reg <= match_cnt_reg + 4'd1;
         end
         if (lock_load) begin
            h_total_reg <= pc_reg;
            v_total_reg <= fc_reg;
         end
         frame_stb_reg <= frame_stb_next;
         loss_reg      <= loss_next;
      end
   end

   assign LOCKED    = (state_reg == LOCK);
   assign H_TOTAL   = h_total_reg;
   assign V_TOTAL   = v_total_reg;
   assign X         = x_reg;
   assign Y         = y_reg;
   assign FRAME_STB = frame_stb_reg;
   assign LOSS      = loss_reg;

endmodule
